// File: rtl/apb_master_bridge_if.sv
// APB3 bus bundle between the bridge (master modport) and the peripheral interconnect (slave modport).
// Handshake: the master holds PSEL with stable PADDR/PWRITE/PWDATA; a transfer completes on the first PENABLE cycle with PREADY=1.
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Core data-bus (req/gnt/rvalid) to single-transfer APB3 bridge, one transaction outstanding.
// Optional ACCESS-phase stall timeout is compiled in with `define APB_BRIDGE_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic                  data_we_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  apb_master_bridge_if.master   apb,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  timeout_hit;
  logic [1:0]            unused_addr_lsb;

  assign unused_addr_lsb = data_addr_i[1:0];

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  // Counts PREADY-low ACCESS cycles; any exit from ACCESS leaves it at zero.
  always_comb begin
    to_cnt_d    = '0;
    timeout_hit = 1'b0;
    if (state_q == ACCESS && !apb.PREADY) begin
      if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
      else                                        to_cnt_d    = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          paddr_d  = {data_addr_i[ADDR_WIDTH-1:2], 2'b00};
          pwdata_d = data_wdata_i;
          pwrite_d = data_we_i;
          rdata_d  = '0;
          // No byte strobes on the fabric, so a partial write is answered locally.
          if (data_we_i && (data_be_i != {BE_WIDTH{1'b1}})) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (apb.PREADY) begin
          rdata_d = pwrite_q ? '0 : apb.PRDATA;
          err_d   = apb.PSLVERR;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_gnt_o    = (state_q == IDLE) && data_req_i && !rst;
  assign data_rvalid_o = (state_q == RESP);
  assign data_rdata_o  = data_rvalid_o ? rdata_q : '0;
  assign data_err_o    = data_rvalid_o ? err_q : 1'b0;

  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb.PENABLE = (state_q == ACCESS);

  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: reset, read, waited write, partial write,
// slave error with back-to-back requests, stall timeout (either build) and reset mid-transfer.
module tb_apb_master_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  apb_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .apb(apb.master), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, exp finish before 500000");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    data_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_wdata_i = wdata; data_be_i = be;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
    apb.PRDATA = '0; apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
    repeat (3) tick();
    data_req_i = 1'b1; #1;
    checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %0b exp 0", data_gnt_o); end
    checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== 34'd0) begin errors++; $display("FAIL rst_resp: got %0h exp 0", {data_rvalid_o, data_err_o, data_rdata_o}); end
    checks++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b exp 000", {apb.PSEL, apb.PENABLE, apb.PWRITE}); end
    checks++; if ({apb.PADDR, apb.PWDATA} !== 64'd0) begin errors++; $display("FAIL rst_bus: got %0h exp 0", {apb.PADDR, apb.PWDATA}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    data_req_i = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    tick();
    issue(1'b0, 32'h1A10_0006, 32'h0, 4'h0);
    exp_q.push_back(32'hDEAD_BEEF);
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %0b exp 1", data_gnt_o); end
    tick(); data_req_i = 1'b0;
    checks++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE} !== 3'b100) begin errors++; $display("FAIL rd_setup: got %b exp 100", {apb.PSEL, apb.PENABLE, apb.PWRITE}); end
    checks++; if (apb.PADDR !== 32'h1A10_0004) begin errors++; $display("FAIL rd_paddr: got %0h exp 1a100004", apb.PADDR); end
    apb.PREADY = 1'b1; apb.PRDATA = 32'hDEAD_BEEF;
    tick();
    checks++; if ({apb.PSEL, apb.PENABLE, data_rvalid_o} !== 3'b110) begin errors++; $display("FAIL rd_access: got %b exp 110", {apb.PSEL, apb.PENABLE, data_rvalid_o}); end
    tick();
    exp_v = exp_q.pop_front();
    checks++; if ({data_rvalid_o, data_err_o, apb.PSEL} !== 3'b100) begin errors++; $display("FAIL rd_resp: got %b exp 100", {data_rvalid_o, data_err_o, apb.PSEL}); end
    checks++; if (data_rdata_o !== exp_v) begin errors++; $display("FAIL rd_rdata: got %0h exp %0h", data_rdata_o, exp_v); end
    apb.PREADY = 1'b0; apb.PRDATA = '0;
    tick();
    checks++; if ({data_rvalid_o, data_rdata_o} !== 33'd0) begin errors++; $display("FAIL rd_after: got %0h exp 0", {data_rvalid_o, data_rdata_o}); end
  endtask

  task automatic test_write_wait();
    tick();
    issue(1'b1, 32'h1A10_0010, 32'h1234_5678, 4'hF);
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %0b exp 1", data_gnt_o); end
    tick(); data_req_i = 1'b0; data_wdata_i = 32'h0;
    checks++; if ({apb.PSEL, apb.PENABLE} !== 2'b10) begin errors++; $display("FAIL wr_setup: got %b exp 10", {apb.PSEL, apb.PENABLE}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      apb.PREADY = (i == 3); apb.PRDATA = 32'hFFFF_FFFF;
      checks++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE, data_rvalid_o} !== 4'b1110) begin errors++; $display("FAIL wr_access%0d: got %b exp 1110", i, {apb.PSEL, apb.PENABLE, apb.PWRITE, data_rvalid_o}); end
      checks++; if ({apb.PADDR, apb.PWDATA} !== {32'h1A10_0010, 32'h1234_5678}) begin errors++; $display("FAIL wr_bus%0d: got %0h exp 1a10001012345678", i, {apb.PADDR, apb.PWDATA}); end
    end
    tick();
    checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL wr_resp: got %0h exp 200000000", {data_rvalid_o, data_err_o, data_rdata_o}); end
    apb.PREADY = 1'b0; apb.PRDATA = '0;
  endtask

  task automatic test_partial_write();
    tick();
    issue(1'b1, 32'h1A10_0020, 32'h0000_AAAA, 4'h3);
    checks++; if ({data_gnt_o, apb.PSEL} !== 2'b10) begin errors++; $display("FAIL pw_gnt: got %b exp 10", {data_gnt_o, apb.PSEL}); end
    tick(); data_req_i = 1'b0;
    checks++; if ({data_rvalid_o, data_err_o, apb.PSEL} !== 3'b110) begin errors++; $display("FAIL pw_resp: got %b exp 110", {data_rvalid_o, data_err_o, apb.PSEL}); end
    checks++; if (data_rdata_o !== 32'h0) begin errors++; $display("FAIL pw_rdata: got %0h exp 0", data_rdata_o); end
    tick();
    checks++; if ({data_rvalid_o, apb.PSEL, apb.PENABLE} !== 3'b000) begin errors++; $display("FAIL pw_after: got %b exp 000", {data_rvalid_o, apb.PSEL, apb.PENABLE}); end
  endtask

  task automatic test_back_to_back();
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b1; apb.PRDATA = 32'h1111_2222;
    tick();
    issue(1'b0, 32'h1A10_0030, 32'h0, 4'h0);
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %0b exp 1", data_gnt_o); end
    tick();
    checks++; if ({data_gnt_o, apb.PSEL} !== 2'b01) begin errors++; $display("FAIL b2b_setup: got %b exp 01", {data_gnt_o, apb.PSEL}); end
    tick();
    checks++; if ({data_gnt_o, apb.PENABLE} !== 2'b01) begin errors++; $display("FAIL b2b_access: got %b exp 01", {data_gnt_o, apb.PENABLE}); end
    tick();
    checks++; if ({data_rvalid_o, data_err_o, data_gnt_o} !== 3'b110) begin errors++; $display("FAIL b2b_slverr: got %b exp 110", {data_rvalid_o, data_err_o, data_gnt_o}); end
    checks++; if (data_rdata_o !== 32'h1111_2222) begin errors++; $display("FAIL b2b_rdata0: got %0h exp 11112222", data_rdata_o); end
    apb.PSLVERR = 1'b0; apb.PRDATA = 32'h3333_4444; data_addr_i = 32'h1A10_0040;
    tick();
    checks++; if ({data_gnt_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL b2b_gnt1: got %b exp 10", {data_gnt_o, data_rvalid_o}); end
    tick(); data_req_i = 1'b0;
    checks++; if (apb.PADDR !== 32'h1A10_0040) begin errors++; $display("FAIL b2b_paddr1: got %0h exp 1a100040", apb.PADDR); end
    tick();
    tick();
    checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {1'b1, 1'b0, 32'h3333_4444}) begin errors++; $display("FAIL b2b_resp1: got %0h exp 233334444", {data_rvalid_o, data_err_o, data_rdata_o}); end
    apb.PREADY = 1'b0; apb.PRDATA = '0;
  endtask

  task automatic test_timeout();
    int rv_seen;
    rv_seen = 0;
    apb.PREADY = 1'b0; apb.PRDATA = 32'hCAFE_F00D;
    tick();
    issue(1'b0, 32'h1A10_0050, 32'h0, 4'h0);
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL to_gnt: got %0b exp 1", data_gnt_o); end
    tick(); data_req_i = 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({apb.PSEL, apb.PENABLE, data_rvalid_o} !== 3'b110) begin errors++; $display("FAIL to_access%0d: got %b exp 110", i, {apb.PSEL, apb.PENABLE, data_rvalid_o}); end
    end
    tick();
    checks++; if ({apb.PSEL, apb.PENABLE, data_rvalid_o, data_err_o} !== 4'b0011) begin errors++; $display("FAIL to_abort: got %b exp 0011", {apb.PSEL, apb.PENABLE, data_rvalid_o, data_err_o}); end
    checks++; if (data_rdata_o !== 32'h0) begin errors++; $display("FAIL to_rdata: got %0h exp 0", data_rdata_o); end
    tick();
    checks++; if ({data_rvalid_o, dbg_state} !== 3'b000) begin errors++; $display("FAIL to_after: got %b exp 000", {data_rvalid_o, dbg_state}); end
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (data_rvalid_o !== 1'b0) rv_seen++;
    end
    checks++; if (rv_seen !== 0) begin errors++; $display("FAIL to_norvalid: got %0d exp 0", rv_seen); end
    checks++; if ({apb.PSEL, apb.PENABLE, dbg_state} !== 4'b1110) begin errors++; $display("FAIL to_waiting: got %b exp 1110", {apb.PSEL, apb.PENABLE, dbg_state}); end
    apb.PREADY = 1'b1;
    tick();
    checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin errors++; $display("FAIL to_release: got %0h exp 2cafef00d", {data_rvalid_o, data_err_o, data_rdata_o}); end
`endif
    apb.PREADY = 1'b0; apb.PRDATA = '0;
  endtask

  task automatic test_reset_mid();
    tick();
    issue(1'b1, 32'h1A10_0060, 32'h5555_AAAA, 4'hF);
    tick(); data_req_i = 1'b0;
    tick();
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rm_access: got %0d exp 2", dbg_state); end
    rst = 1'b1; apb.PREADY = 1'b1;
    tick();
    rst = 1'b0; apb.PREADY = 1'b0;
    checks++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE, data_rvalid_o, data_err_o, dbg_state} !== 7'd0) begin errors++; $display("FAIL rm_ctrl: got %b exp 0000000", {apb.PSEL, apb.PENABLE, apb.PWRITE, data_rvalid_o, data_err_o, dbg_state}); end
    checks++; if ({apb.PADDR, apb.PWDATA, data_rdata_o} !== 96'd0) begin errors++; $display("FAIL rm_bus: got %0h exp 0", {apb.PADDR, apb.PWDATA, data_rdata_o}); end
    tick();
    checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL rm_norvalid: got %0b exp 0", data_rvalid_o); end
    issue(1'b0, 32'h1A10_0070, 32'h0, 4'h0);
    exp_q.push_back(32'h0BAD_F00D);
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %0b exp 1", data_gnt_o); end
    tick(); data_req_i = 1'b0;
    apb.PREADY = 1'b1; apb.PRDATA = 32'h0BAD_F00D;
    tick();
    tick();
    exp_v = exp_q.pop_front();
    checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {1'b1, 1'b0, exp_v}) begin errors++; $display("FAIL rm_read: got %0h exp %0h", {data_rvalid_o, data_err_o, data_rdata_o}, {1'b1, 1'b0, exp_v}); end
    apb.PREADY = 1'b0; apb.PRDATA = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_partial_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
